morra_cinese_match: RTL and testbench
=====================================

# morra_cinese_match

Parametrised rock-paper-scissors ("morra cinese") referee with a best-of-N match layer on top of per-game scoring. Two players submit 2-bit moves under a valid strobe. The block scores each round, decides each game by margin or round limit, and tallies games into a match result. It is the successor of the fixed single-game MorraCinese FSMD and sits between the player input logic and the score display.

## Interface
- MIN_ROUNDS, 4: valid rounds a game always lasts before a margin win can end it.
- WIN_MARGIN, 2: advantage that ends a game once MIN_ROUNDS is reached.
- MATCH_GAMES, 3: games in a match. Odd, 1..15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- START  in  1  start or restart a game. Sampled each rising edge.
- MOVE_VALID  in  1  P1/P2 carry a round's moves this cycle.
- P1  in  2  player 1 move: 00 none, 01 rock, 10 paper, 11 scissors. Also game config when START=1.
- P2  in  2  player 2 move, same encoding.
- ROUND  out  2  round result: 00 none/invalid, 01 P1, 10 P2, 11 tie.
- GAME  out  2  game result: 00 running/idle, 01 P1, 10 P2, 11 draw.
- MATCH  out  2  match result, same encoding as GAME.
- WINS1  out  4  games won by P1 in the current match.
- WINS2  out  4  games won by P2 in the current match.

## Operation
- States: IDLE, PLAY, GAME_OVER, MATCH_OVER. Reset enters IDLE.
- START=1 in any state:
  - Latches cfg={P1,P2} and sets max_rounds = MIN_ROUNDS + cfg.
  - Clears the round counter, advantage and the no-repeat memory, then enters PLAY.
  - In IDLE or MATCH_OVER it also clears WINS1, WINS2, games_played and MATCH.
  - In PLAY, the aborted game is not counted.
- START has priority over MOVE_VALID in the same cycle.
- PLAY with MOVE_VALID=1 and START=0:
  - Either move is 00 → ROUND=00. The round is not counted and state is unchanged.
  - Otherwise the round is scored: paper beats rock, rock beats scissors, scissors beats paper, equal moves tie.
  - The round counter increments. adv += 1 on a P1 win, −1 on a P2 win, 0 on a tie.
- MOVE_VALID=0, or any state other than PLAY → ROUND=00 and no state change.
- Game end is checked on the post-update values:
  - rounds ≥ MIN_ROUNDS and |adv| ≥ WIN_MARGIN → winner is the sign of adv.
  - Otherwise, rounds == max_rounds → winner is the sign of adv; adv=0 gives a draw (GAME=11).
- On game end:
  - GAME is set, the winner's WINSx increments and games_played increments.
  - Next state is GAME_OVER, or MATCH_OVER when either WINSx reaches (MATCH_GAMES+1)/2 or games_played == MATCH_GAMES.
- MATCH on entering MATCH_OVER: the higher WINSx wins; equal wins give 11.
- GAME and MATCH hold their values until the next START clears them to 00.
- Moves presented in GAME_OVER or MATCH_OVER are ignored.
- Widths:
  - Round counter: $clog2(MIN_ROUNDS+16) bits.
  - adv: signed, one bit wider than the round counter; cannot overflow before max_rounds.

## Timing
- All outputs are registered. Reset value of every output is 0.
- ROUND, GAME, WINSx and MATCH reflect the inputs sampled at edge k from edge k onward; observe them one cycle after the stimulus.
- ROUND is a one-cycle result: it returns to 00 on any cycle without a scored round.
- The final round of a game produces ROUND and GAME on the same edge.
- Back-to-back MOVE_VALID is supported at one round per cycle.
- rst_n asserted mid-game aborts immediately and returns to IDLE with everything cleared. Deassertion is synchronised externally.

## Configuration
- MORRA_NO_REPEAT_EN defined:
  - The winner of the last scored round may not play that same winning move in the next valid round.
  - A violating round gives ROUND=00 and is not counted; the restriction stays in force.
  - A tie or START clears the restriction.
- MORRA_NO_REPEAT_EN undefined: no restriction. The memory registers are not built.

## Structure
- Package morra_pkg holds:
  - move_t enum: NONE, ROCK, PAPER, SCISSORS.
  - result_t enum: NONE, P1, P2, TIE/DRAW.
  - state_t enum.
  - A beats() function.
- Sub-module morra_round_judge: purely combinational. Takes two moves plus the optional restriction and returns result_t. It is instantiated once.

## Test plan
- Reset, then START with P1=00, P2=00 (max 4), then four ties. The fourth round gives ROUND=11 and GAME=11; WINS1=WINS2=0.
- START with P1=00, P2=01 (max 5):
  - P1 paper vs rock for rounds 1–2 → adv +2 at round 2.
  - Rounds 3–4 tie.
  - Result: GAME=01 at round 4, WINS1=1.
- P2=00 inside a game → ROUND=00 and the round count is unchanged. A following valid round is counted.
- Three games all won by P1 with MATCH_GAMES=3 → after the second game MATCH=01 and state is MATCH_OVER. Further moves are ignored; START clears WINSx.
- With MORRA_NO_REPEAT_EN, P1 wins with rock and then plays rock again → ROUND=00 and not counted. After a tie, rock is accepted.
- rst_n pulsed low mid-game with adv=+1 → all outputs 0 asynchronously. A following START begins a fresh match.

Source files
------------

// File: rtl/morra_pkg.sv
// morra_pkg: shared types and helpers for the rock-paper-scissors match referee.
// Optional feature macro used by the design: MORRA_NO_REPEAT_EN.
package morra_pkg;

  // Move encoding as seen on the P1/P2 pins.
  typedef enum logic [1:0] {
    MV_NONE     = 2'b00,
    MV_ROCK     = 2'b01,
    MV_PAPER    = 2'b10,
    MV_SCISSORS = 2'b11
  } move_t;

  // Result encoding shared by ROUND, GAME and MATCH (TIE doubles as DRAW).
  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_TIE  = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAME_OVER,
    ST_MATCH_OVER
  } state_t;

  // True when move a defeats move b (NONE never beats anything).
  function automatic logic beats(input move_t a, input move_t b);
    return ((a == MV_PAPER)    && (b == MV_ROCK))     ||
           ((a == MV_ROCK)     && (b == MV_SCISSORS)) ||
           ((a == MV_SCISSORS) && (b == MV_PAPER));
  endfunction

endpackage

// File: rtl/morra_round_judge.sv
// morra_round_judge: combinational scoring of a single round.
// Returns RES_NONE when a move is missing or when the previous round's winner
// repeats the move that is currently barred (restr_en_i set).
module morra_round_judge
  import morra_pkg::*;
(
  input  move_t   p1_i,
  input  move_t   p2_i,
  input  logic    restr_en_i,
  input  logic    restr_p2_i,
  input  move_t   restr_move_i,
  output result_t result_o
);

  // Score the round, rejecting missing moves and barred repeats first.
  always_comb begin
    result_o = RES_NONE;
    if ((p1_i != MV_NONE) && (p2_i != MV_NONE)) begin
      if (restr_en_i && !restr_p2_i && (p1_i == restr_move_i)) begin
        result_o = RES_NONE;
      end else if (restr_en_i && restr_p2_i && (p2_i == restr_move_i)) begin
        result_o = RES_NONE;
      end else if (p1_i == p2_i) begin
        result_o = RES_TIE;
      end else if (beats(p1_i, p2_i)) begin
        result_o = RES_P1;
      end else begin
        result_o = RES_P2;
      end
    end
  end

endmodule

// File: rtl/morra_cinese_match.sv
// morra_cinese_match: best-of-MATCH_GAMES rock-paper-scissors referee.
// Games end on a WIN_MARGIN lead after MIN_ROUNDS rounds, or at the
// configured round limit (MIN_ROUNDS + {P1,P2} latched at START).
// Optional feature macro: MORRA_NO_REPEAT_EN (bars the last round winner
// from repeating its winning move until a tie or START).
module morra_cinese_match
  import morra_pkg::*;
#(
  parameter int MIN_ROUNDS  = 4,
  parameter int WIN_MARGIN  = 2,
  parameter int MATCH_GAMES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       START,
  input  logic       MOVE_VALID,
  input  logic [1:0] P1,
  input  logic [1:0] P2,
  output logic [1:0] ROUND,
  output logic [1:0] GAME,
  output logic [1:0] MATCH,
  output logic [3:0] WINS1,
  output logic [3:0] WINS2
);

  // Round counter must hold MIN_ROUNDS + 15; advantage is one bit wider and signed.
  localparam int RW = $clog2(MIN_ROUNDS + 16);
  localparam int AW = RW + 1;
  localparam logic [RW-1:0]        MIN_R       = RW'(MIN_ROUNDS);
  localparam logic signed [AW-1:0] MARGIN      = AW'(WIN_MARGIN);
  localparam logic signed [AW-1:0] ONE_S       = AW'(1);
  localparam logic [3:0]           WINS_NEED   = 4'((MATCH_GAMES + 1) / 2);
  localparam logic [3:0]           GAMES_TOTAL = 4'(MATCH_GAMES);

  state_t                 state_q, state_d;
  result_t                round_q, round_d;
  result_t                game_q, game_d;
  result_t                match_q, match_d;
  logic [3:0]             wins1_q, wins1_d;
  logic [3:0]             wins2_q, wins2_d;
  logic [3:0]             games_q, games_d;
  logic [RW-1:0]          rounds_q, rounds_d;
  logic [RW-1:0]          max_rounds_q, max_rounds_d;
  logic signed [AW-1:0]   adv_q, adv_d;
  result_t                judge_res;

  // Restriction seen by the judge: registered when the feature is built, constant otherwise.
  logic                   restr_en;
  logic                   restr_p2;
  move_t                  restr_move;

`ifdef MORRA_NO_REPEAT_EN
  logic                   restr_en_q, restr_en_d;
  logic                   restr_p2_q, restr_p2_d;
  move_t                  restr_move_q, restr_move_d;

  assign restr_en   = restr_en_q;
  assign restr_p2   = restr_p2_q;
  assign restr_move = restr_move_q;

  // No-repeat memory: which player is barred and from which move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      restr_en_q   <= 1'b0;
      restr_p2_q   <= 1'b0;
      restr_move_q <= MV_NONE;
    end else begin
      restr_en_q   <= restr_en_d;
      restr_p2_q   <= restr_p2_d;
      restr_move_q <= restr_move_d;
    end
  end
`else
  assign restr_en   = 1'b0;
  assign restr_p2   = 1'b0;
  assign restr_move = MV_NONE;
`endif

  morra_round_judge u_judge (
    .p1_i         (move_t'(P1)),
    .p2_i         (move_t'(P2)),
    .restr_en_i   (restr_en),
    .restr_p2_i   (restr_p2),
    .restr_move_i (restr_move),
    .result_o     (judge_res)
  );

  // Match state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      round_q      <= RES_NONE;
      game_q       <= RES_NONE;
      match_q      <= RES_NONE;
      wins1_q      <= '0;
      wins2_q      <= '0;
      games_q      <= '0;
      rounds_q     <= '0;
      max_rounds_q <= '0;
      adv_q        <= '0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      game_q       <= game_d;
      match_q      <= match_d;
      wins1_q      <= wins1_d;
      wins2_q      <= wins2_d;
      games_q      <= games_d;
      rounds_q     <= rounds_d;
      max_rounds_q <= max_rounds_d;
      adv_q        <= adv_d;
    end
  end

  // Next state: START handling, round scoring, game and match end detection.
  always_comb begin
    state_d      = state_q;
    round_d      = RES_NONE;
    game_d       = game_q;
    match_d      = match_q;
    wins1_d      = wins1_q;
    wins2_d      = wins2_q;
    games_d      = games_q;
    rounds_d     = rounds_q;
    max_rounds_d = max_rounds_q;
    adv_d        = adv_q;
`ifdef MORRA_NO_REPEAT_EN
    restr_en_d   = restr_en_q;
    restr_p2_d   = restr_p2_q;
    restr_move_d = restr_move_q;
`endif

    if (START) begin
      // Fresh game; a game in progress is simply dropped.
      max_rounds_d = MIN_R + RW'({P1, P2});
      rounds_d     = '0;
      adv_d        = '0;
      game_d       = RES_NONE;
      match_d      = RES_NONE;
      state_d      = ST_PLAY;
`ifdef MORRA_NO_REPEAT_EN
      restr_en_d   = 1'b0;
`endif
      if ((state_q == ST_IDLE) || (state_q == ST_MATCH_OVER)) begin
        wins1_d = '0;
        wins2_d = '0;
        games_d = '0;
      end
    end else if ((state_q == ST_PLAY) && MOVE_VALID && (judge_res != RES_NONE)) begin
      round_d  = judge_res;
      rounds_d = rounds_q + RW'(1);
      if (judge_res == RES_P1) begin
        adv_d = adv_q + ONE_S;
      end else if (judge_res == RES_P2) begin
        adv_d = adv_q - ONE_S;
      end
`ifdef MORRA_NO_REPEAT_EN
      restr_en_d   = (judge_res != RES_TIE);
      restr_p2_d   = (judge_res == RES_P2);
      restr_move_d = (judge_res == RES_P2) ? move_t'(P2) : move_t'(P1);
`endif
      // Game end uses the post-update counter and advantage.
      if (((rounds_d >= MIN_R) && ((adv_d >= MARGIN) || (adv_d <= -MARGIN))) ||
          (rounds_d == max_rounds_q)) begin
        games_d = games_q + 4'd1;
        state_d = ST_GAME_OVER;
        if (adv_d == '0) begin
          game_d = RES_TIE;
        end else if (adv_d[AW-1]) begin
          game_d  = RES_P2;
          wins2_d = wins2_q + 4'd1;
        end else begin
          game_d  = RES_P1;
          wins1_d = wins1_q + 4'd1;
        end
        if ((wins1_d >= WINS_NEED) || (wins2_d >= WINS_NEED) || (games_d == GAMES_TOTAL)) begin
          state_d = ST_MATCH_OVER;
          if (wins1_d > wins2_d) begin
            match_d = RES_P1;
          end else if (wins2_d > wins1_d) begin
            match_d = RES_P2;
          end else begin
            match_d = RES_TIE;
          end
        end
      end
    end
  end

  assign ROUND = round_q;
  assign GAME  = game_q;
  assign MATCH = match_q;
  assign WINS1 = wins1_q;
  assign WINS2 = wins2_q;

endmodule

// File: tb/tb_morra_cinese_match.sv
// tb_morra_cinese_match: table-driven vectors, directed corner sequences and
// randomized play checked against a behavioural match model.
module tb_morra_cinese_match;

  localparam int MIN_ROUNDS  = 4;
  localparam int WIN_MARGIN  = 2;
  localparam int MATCH_GAMES = 3;
  localparam int NEED        = (MATCH_GAMES + 1) / 2;
`ifdef MORRA_NO_REPEAT_EN
  localparam bit NO_REPEAT = 1'b1;
`else
  localparam bit NO_REPEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       START = 1'b0;
  logic       MOVE_VALID = 1'b0;
  logic [1:0] P1 = 2'b00;
  logic [1:0] P2 = 2'b00;
  logic [1:0] ROUND, GAME, MATCH;
  logic [3:0] WINS1, WINS2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  morra_cinese_match #(
    .MIN_ROUNDS  (MIN_ROUNDS),
    .WIN_MARGIN  (WIN_MARGIN),
    .MATCH_GAMES (MATCH_GAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .START      (START),
    .MOVE_VALID (MOVE_VALID),
    .P1         (P1),
    .P2         (P2),
    .ROUND      (ROUND),
    .GAME       (GAME),
    .MATCH      (MATCH),
    .WINS1      (WINS1),
    .WINS2      (WINS2)
  );

  // ---------------- behavioural model ----------------
  int m_rounds, m_adv, m_max, m_w1, m_w2, m_gp;
  bit m_playing, m_match_open, m_restr;
  int m_rp, m_rmove;
  int e_round, e_game, e_match;

  task automatic model_reset();
    m_rounds = 0; m_adv = 0; m_max = 0; m_w1 = 0; m_w2 = 0; m_gp = 0;
    m_playing = 0; m_match_open = 0; m_restr = 0; m_rp = 0; m_rmove = 0;
    e_round = 0; e_game = 0; e_match = 0;
  endtask

  task automatic model_step(input bit st, input bit mv, input int a, input int b);
    int d;
    bit barred;
    e_round = 0;
    barred = NO_REPEAT && m_restr && (((m_rp == 1) && (a == m_rmove)) || ((m_rp == 2) && (b == m_rmove)));
    if (st) begin
      if (!m_match_open) begin
        m_w1 = 0; m_w2 = 0; m_gp = 0;
      end
      m_match_open = 1; m_playing = 1;
      e_game = 0; e_match = 0;
      m_rounds = 0; m_adv = 0; m_restr = 0;
      m_max = MIN_ROUNDS + 4 * a + b;
    end else if (m_playing && mv && (a != 0) && (b != 0) && !barred) begin
      // rock=1, paper=2, scissors=3: (a-b) mod 3 == 1 means a wins
      d = (a - b + 3) % 3;
      m_rounds++;
      if (d == 0) begin
        e_round = 3; m_restr = 0;
      end else if (d == 1) begin
        e_round = 1; m_adv++; m_restr = 1; m_rp = 1; m_rmove = a;
      end else begin
        e_round = 2; m_adv--; m_restr = 1; m_rp = 2; m_rmove = b;
      end
      if (((m_rounds >= MIN_ROUNDS) && ((m_adv >= WIN_MARGIN) || (-m_adv >= WIN_MARGIN))) ||
          (m_rounds == m_max)) begin
        m_playing = 0;
        m_gp++;
        if (m_adv > 0) begin
          e_game = 1; m_w1++;
        end else if (m_adv < 0) begin
          e_game = 2; m_w2++;
        end else begin
          e_game = 3;
        end
        if ((m_w1 >= NEED) || (m_w2 >= NEED) || (m_gp == MATCH_GAMES)) begin
          m_match_open = 0;
          e_match = (m_w1 > m_w2) ? 1 : ((m_w2 > m_w1) ? 2 : 3);
        end
      end
    end
  endtask

  // ---------------- helpers ----------------
  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // One clock: drive, sample at the edge, look #1 later, advance the model.
  task automatic cycle(input logic st, input logic mv, input logic [1:0] a, input logic [1:0] b);
    START = st; MOVE_VALID = mv; P1 = a; P2 = b;
    @(posedge clk);
    #1;
    model_step(st, mv, int'(a), int'(b));
  endtask

  function automatic void chk_model(input string tag);
    chk({tag, ".round"}, int'(ROUND), e_round);
    chk({tag, ".game"},  int'(GAME),  e_game);
    chk({tag, ".match"}, int'(MATCH), e_match);
    chk({tag, ".wins1"}, int'(WINS1), m_w1);
    chk({tag, ".wins2"}, int'(WINS2), m_w2);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       st;
    logic       mv;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] rnd;
    logic [1:0] gm;
    logic [1:0] mt;
    logic [3:0] w1;
    logic [3:0] w2;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, input logic mv, input logic [1:0] a, input logic [1:0] b,
                     input logic [1:0] r, input logic [1:0] g, input logic [1:0] m,
                     input logic [3:0] x, input logic [3:0] y);
    vec_t v;
    v.st = st; v.mv = mv; v.p1 = a; v.p2 = b;
    v.rnd = r; v.gm = g; v.mt = m; v.w1 = x; v.w2 = y;
    vq.push_back(v);
  endtask

  initial begin
    model_reset();
    // Game 1 (max 4): four ties end in a draw at the round limit.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 3, 0, 0, 0, 0);
    add(0, 1, 1, 1, 3, 3, 0, 0, 0);
    // Game 2 (max 5): paper beats rock twice, a missing move, then two ties.
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 2, 1, 1, 0, 0, 0, 0);
    add(0, 1, 2, 1, 1, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 3, 0, 0, 0, 0);
    add(0, 1, 1, 1, 3, 1, 0, 1, 0);
    add(0, 1, 1, 3, 0, 1, 0, 1, 0);
    add(0, 0, 2, 1, 0, 1, 0, 1, 0);
    // Game 3: scissors beats paper, P1 reaches two wins -> match over.
    add(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 3, 2, 1, 0, 0, 1, 0);
    add(0, 1, 3, 2, 1, 1, 1, 2, 0);
    add(0, 1, 2, 1, 0, 1, 1, 2, 0);
    // New match, game at round limit (max 5) with adv +1.
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 2, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 2, 2, 0, 0, 0, 0);
    add(0, 1, 3, 3, 3, 0, 0, 0, 0);
    add(0, 1, 2, 2, 3, 0, 0, 0, 0);
    add(0, 1, 1, 3, 1, 1, 0, 1, 0);
    // Second P1 game ends the match after two games.
    add(1, 0, 2, 3, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 3, 1, 0, 0, 1, 0);
    add(0, 1, 1, 3, 1, 1, 1, 2, 0);
    add(0, 1, 1, 3, 0, 1, 1, 2, 0);
    // START wins over MOVE_VALID and clears the finished match.
    add(1, 1, 1, 3, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2, 2, 0, 0, 0, 0);
    // Abort in PLAY: the dropped game is not tallied; then P2 wins a game.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 2, 2, 0, 0, 0, 0);
    add(0, 1, 1, 2, 2, 2, 0, 0, 1);

    // Reset state.
    #2;
    chk("reset.round", int'(ROUND), 0);
    chk("reset.game",  int'(GAME),  0);
    chk("reset.wins1", int'(WINS1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      cycle(vq[i].st, vq[i].mv, vq[i].p1, vq[i].p2);
      $display("vec %0d st=%0d mv=%0d p1=%0d p2=%0d -> round=%0d game=%0d match=%0d w1=%0d w2=%0d",
               i, vq[i].st, vq[i].mv, vq[i].p1, vq[i].p2, ROUND, GAME, MATCH, WINS1, WINS2);
      chk($sformatf("vec%0d.round", i), int'(ROUND), int'(vq[i].rnd));
      chk($sformatf("vec%0d.game", i),  int'(GAME),  int'(vq[i].gm));
      chk($sformatf("vec%0d.match", i), int'(MATCH), int'(vq[i].mt));
      chk($sformatf("vec%0d.wins1", i), int'(WINS1), int'(vq[i].w1));
      chk($sformatf("vec%0d.wins2", i), int'(WINS2), int'(vq[i].w2));
    end

    // Asynchronous reset mid-game with adv=+1 (WINS2=1 carried in).
    cycle(1, 0, 0, 0);
    cycle(0, 1, 2, 1);
    $display("pre-reset round=%0d w2=%0d", ROUND, WINS2);
    chk("prerst.round", int'(ROUND), 1);
    chk("prerst.wins2", int'(WINS2), 1);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset round=%0d game=%0d match=%0d w1=%0d w2=%0d", ROUND, GAME, MATCH, WINS1, WINS2);
    chk("arst.round", int'(ROUND), 0);
    chk("arst.wins2", int'(WINS2), 0);
    chk("arst.game",  int'(GAME),  0);
    chk("arst.match", int'(MATCH), 0);
    model_reset();
    #2 rst_n = 1'b1;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 3, 2);
    $display("post-reset round=%0d w1=%0d w2=%0d", ROUND, WINS1, WINS2);
    chk("postrst.round", int'(ROUND), 1);
    chk("postrst.wins2", int'(WINS2), 0);

`ifdef MORRA_NO_REPEAT_EN
    // Winner may not repeat the winning move until a tie.
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 3);
    chk("norep.win", int'(ROUND), 1);
    cycle(0, 1, 1, 2);
    $display("norep repeat round=%0d", ROUND);
    chk("norep.barred", int'(ROUND), 0);
    cycle(0, 1, 3, 3);
    chk("norep.tie", int'(ROUND), 3);
    cycle(0, 1, 1, 3);
    $display("norep after tie round=%0d", ROUND);
    chk("norep.accept", int'(ROUND), 1);
`endif

    // Randomised play against the model.
    for (int n = 0; n < 600; n++) begin
      logic st, mv;
      logic [1:0] a, b;
      st = m_playing ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      mv = ($urandom_range(0, 3) != 0);
      a  = st ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      b  = 2'($urandom_range(0, 3));
      cycle(st, mv, a, b);
      $display("rnd %0d st=%0d mv=%0d p1=%0d p2=%0d -> round=%0d game=%0d match=%0d w1=%0d w2=%0d",
               n, st, mv, a, b, ROUND, GAME, MATCH, WINS1, WINS2);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
